// File: rtl/prod_bcd_pkg.sv
// Shared types and constants for the product-to-BCD conversion stage.
package prod_bcd_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int PROD_W = 9;
  localparam int BCD_DIGITS = 3;
  localparam logic [3:0] ADJ_THRESH = 4'd5;
endpackage

// File: rtl/prod_bcd_conv_digit_adj.sv
// Double-dabble digit correction: a digit of 5 or more gets 3 added before the shift.
module bcd_digit_adj
  import prod_bcd_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= ADJ_THRESH) ? d + 4'd3 : d;
endmodule

// File: rtl/prod_bcd_conv.sv
// Sequential binary-to-BCD converter: one adjust-and-shift step per clock, valid/ready on both sides.
module prod_bcd_conv
  import prod_bcd_pkg::*;
#(
  parameter int IN_W   = PROD_W,
  parameter int DIGITS = BCD_DIGITS,
  parameter int CNT_W  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_W-1:0]     bin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] bcd,
  output logic                ovf
);
  localparam int BW = 4 * DIGITS;

  state_t           st, nst;
  logic [IN_W-1:0]  sr;
  logic [BW-1:0]    acc, adj;
  logic [CNT_W-1:0] cnt;
  logic             ovf_r;
  logic             last;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (.d(acc[4*g +: 4]), .q(adj[4*g +: 4]));
  end

  assign last = (cnt == CNT_W'(IN_W - 1));

  always_ff @(posedge clk) begin
    if (reset) st <= IDLE;
    else       st <= nst;
  end

  always_comb begin
    nst = st;
    unique case (st)
      IDLE:    if (in_valid)  nst = SHIFT;
      SHIFT:   if (last)      nst = DONE;
      DONE:    if (out_ready) nst = IDLE;
      default:                nst = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (st == IDLE);
    out_valid = (st == DONE);
  end

  // {acc, sr} shifts as one register; the bit leaving the top digit marks overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr    <= '0;
      acc   <= '0;
      cnt   <= '0;
      ovf_r <= 1'b0;
    end else begin
      unique case (st)
        IDLE: if (in_valid) begin
          sr    <= bin;
          acc   <= '0;
          cnt   <= '0;
          ovf_r <= 1'b0;
        end
        SHIFT: begin
          {acc, sr} <= {adj[BW-2:0], sr, 1'b0};
          ovf_r     <= ovf_r | adj[BW-1];
          cnt       <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bcd = acc;
  assign ovf = ovf_r;
endmodule

// File: tb/tb_prod_bcd_conv.sv
// Bench for prod_bcd_conv: arithmetic reference model checked every cycle plus directed literal checks.
module tb_prod_bcd_conv;
  localparam int IN_W = 9;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, ovf;
  logic [8:0]  bin = '0;
  logic [11:0] bcd;

  logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1, b_ovf;
  logic [8:0]  b_bin = '0;
  logic [7:0]  b_bcd;

  int total = 0, bad = 0;
  bit started = 0;

  always #5 clk = ~clk;

  prod_bcd_conv u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .bin(bin),
    .out_valid(out_valid), .out_ready(out_ready), .bcd(bcd), .ovf(ovf)
  );

  prod_bcd_conv #(.IN_W(9), .DIGITS(2), .CNT_W(4)) u_dut2 (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready), .bin(b_bin),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .bcd(b_bcd), .ovf(b_ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Decimal digits by plain division; overflow when the value needs more digits.
  function automatic logic [12:0] ref_bcd(input int v, input int digits);
    logic [11:0] r;
    int p;
    r = '0;
    p = 1;
    for (int d = 0; d < digits; d++) begin
      r[4*d +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return {logic'(v >= p), r};
  endfunction

  // Reference: 0 idle, 1 converting (countdown), 2 holding result.
  int          mphase = 0, mleft = 0;
  logic [11:0] mbcd = '0;
  logic        movf = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      mphase = 0; mbcd = '0; movf = 1'b0;
    end else begin
      case (mphase)
        0: if (in_valid) begin
          mphase = 1; mleft = IN_W;
          {movf, mbcd} = ref_bcd(int'(bin), 3);
        end
        1: begin
          mleft--;
          if (mleft == 0) mphase = 2;
        end
        default: if (out_ready) mphase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("in_ready", {31'd0, in_ready}, {31'd0, mphase == 0});
      check("out_valid", {31'd0, out_valid}, {31'd0, mphase == 2});
      if (mphase != 1) begin
        check("bcd", {20'd0, bcd}, {20'd0, mbcd});
        check("ovf", {31'd0, ovf}, {31'd0, movf});
      end
    end
  end

  logic [11:0] q[$];
  always @(negedge clk)
    if (started && !reset && out_valid && out_ready) q.push_back(bcd);

  task automatic send(input logic [8:0] v);
    bit a;
    a = 0;
    in_valid = 1'b1;
    bin = v;
    for (int i = 0; i < 60 && !a; i++) begin
      a = in_ready;
      @(posedge clk); #2;
    end
    in_valid = 1'b0;
    if (!a) begin
      total++; bad++;
      $display("FAIL send_timeout: got no accept want accept of %0d", v);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 60) begin
      @(posedge clk); #2;
      n++;
    end
    if (!out_valid) begin
      total++; bad++;
      $display("FAIL out_timeout: got out_valid=0 want 1 after %0d edges", n);
    end
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #2;
    started = 1;
    reset = 1'b0;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_bcd", {20'd0, bcd}, 32'h000);
    check("rst_ovf", {31'd0, ovf}, 32'd0);

    // single conversion with latency check
    send(9'd50);
    wait_valid(n);
    check("lat50", n, 32'd9);
    check("bcd50", {20'd0, bcd}, 32'h050);
    check("ovf50", {31'd0, ovf}, 32'd0);
    @(posedge clk); #2;
    check("ready_after50", {31'd0, in_ready}, 32'd1);
    q.delete();

    // boundary sweep with in_valid effectively held high
    send(9'd0);
    send(9'd225);
    send(9'd511);
    n = 0;
    while (q.size() < 3 && n < 60) begin
      @(posedge clk); #2;
      n++;
    end
    check("sweep_count", q.size(), 32'd3);
    if (q.size() >= 3) begin
      check("sweep0", {20'd0, q[0]}, 32'h000);
      check("sweep225", {20'd0, q[1]}, 32'h225);
      check("sweep511", {20'd0, q[2]}, 32'h511);
    end

    // backpressure
    out_ready = 1'b0;
    send(9'd99);
    wait_valid(n);
    repeat (20) begin @(posedge clk); #2; end
    check("bp_bcd", {20'd0, bcd}, 32'h099);
    check("bp_valid", {31'd0, out_valid}, 32'd1);
    check("bp_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #2;
    check("bp_idle", {31'd0, in_ready}, 32'd1);
    check("bp_released", {31'd0, out_valid}, 32'd0);

    // reset in the middle of a conversion
    send(9'd300);
    repeat (3) begin @(posedge clk); #2; end
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_bcd", {20'd0, bcd}, 32'h000);
    send(9'd7);
    wait_valid(n);
    check("bcd7", {20'd0, bcd}, 32'h007);
    @(posedge clk); #2;

    // two-digit instance: overflow and largest fitting value
    b_bin = 9'd150;
    b_in_valid = 1'b1;
    @(posedge clk); #2;
    b_in_valid = 1'b0;
    n = 0;
    while (!b_out_valid && n < 60) begin @(posedge clk); #2; n++; end
    check("d2_lat150", n, 32'd9);
    check("d2_ovf150", {31'd0, b_ovf}, 32'd1);
    @(posedge clk); #2;
    b_bin = 9'd99;
    b_in_valid = 1'b1;
    @(posedge clk); #2;
    b_in_valid = 1'b0;
    n = 0;
    while (!b_out_valid && n < 60) begin @(posedge clk); #2; n++; end
    check("d2_valid99", {31'd0, b_out_valid}, 32'd1);
    check("d2_bcd99", {24'd0, b_bcd}, 32'h99);
    check("d2_ovf99", {31'd0, b_ovf}, 32'd0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
